// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and the response FSM states.
package alu_arb_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt_onehot,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    any
);

  localparam int IDW = $clog2(NREQ);

  int w_idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = (int'(ptr) + i) % NREQ;
      if (!any && req[w_idx]) begin
        any               = 1'b1;
        gnt_idx           = IDW'(w_idx);
        gnt_onehot[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters with a one-deep registered response.
// Optional performance counters (perf_ops, perf_stall) are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_op1,
  input  logic [NREQ*WIDTH-1:0]   req_op2,
  input  logic [NREQ*4-1:0]       req_ctrl,
  output logic [WIDTH-1:0]        alu_op1,
  output logic [WIDTH-1:0]        alu_op2,
  output logic [3:0]              alu_control,
  input  logic [WIDTH-1:0]        alu_result,
  input  logic [3:0]              alu_flags,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_result,
  output logic [3:0]              rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]             perf_ops,
  output logic [31:0]             perf_stall
`endif
);

  localparam int IDW = $clog2(NREQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;

  logic [NREQ-1:0]  w_gnt_onehot;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_any;
  logic             w_issue_en;
  logic             w_hs;
  logic [IDW-1:0]   w_ptr_nxt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .ptr        (r_rr_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  // Reset gates issue so no request can be accepted in a reset cycle.
  always_comb begin
    w_issue_en  = !reset && ((r_state == ST_IDLE) || rsp_ready);
    w_hs        = w_issue_en && w_any;
    req_ready   = w_issue_en ? w_gnt_onehot : '0;
    alu_op1     = '0;
    alu_op2     = '0;
    alu_control = '0;
    if (w_any) begin
      alu_op1     = req_op1[int'(w_gnt_idx)*WIDTH +: WIDTH];
      alu_op2     = req_op2[int'(w_gnt_idx)*WIDTH +: WIDTH];
      alu_control = req_ctrl[int'(w_gnt_idx)*4 +: 4];
    end
    w_ptr_nxt = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_hs) begin
      w_state_nxt = ST_RESP;
    end else if ((r_state == ST_RESP) && rsp_ready) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else if (w_hs) begin
      r_rr_ptr     <= w_ptr_nxt;
      r_rsp_id     <= w_gnt_idx;
      r_rsp_result <= alu_result;
      r_rsp_flags  <= alu_flags;
    end
  end

  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_hs) r_perf_ops <= r_perf_ops + 32'd1;
      if ((r_state == ST_RESP) && !rsp_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_ops   = r_perf_ops;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a round-robin model predicts grants and queues expected responses.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_op1;
  logic [NREQ*32-1:0] req_op2;
  logic [NREQ*4-1:0]  req_ctrl;
  logic [31:0]        alu_op1;
  logic [31:0]        alu_op2;
  logic [3:0]         alu_control;
  logic [31:0]        alu_result;
  logic [3:0]         alu_flags;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [31:0]        rsp_result;
  logic [3:0]         rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic [31:0]        perf_ops;
  logic [31:0]        perf_stall;
`endif

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_ctrl    (req_ctrl),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags)
`ifdef ALU_ARB_STATS_EN
    ,
    .perf_ops    (perf_ops),
    .perf_stall  (perf_stall)
`endif
  );

  function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] flagFn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic [31:0] r;
    r = aluFn(a, b, c);
    return {(r == 32'd0), r[31], a[0], b[0]};
  endfunction

  // Stand-in for the shared combinational ALU.
  assign alu_result = aluFn(alu_op1, alu_op2, alu_control);
  assign alu_flags  = flagFn(alu_op1, alu_op2, alu_control);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t        sb[$];
  exp_t        eTmp;
  int          total;
  int          bad;
  int          mPtr;
  bit          mHold;
  logic [3:0]  expReady;
  bit          expHs;
  bit          expAny;
  int          expG;
  logic [31:0] opA[NREQ];
  logic [31:0] opB[NREQ];
  logic [3:0]  opC[NREQ];

  task automatic setOp(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    opA[i] = a;
    opB[i] = b;
    opC[i] = c;
    req_op1[i*32 +: 32] = a;
    req_op2[i*32 +: 32] = b;
    req_ctrl[i*4 +: 4]  = c;
  endtask

  // Drives one cycle of inputs and predicts the grant from the model pointer.
  task automatic applyStimulus(input logic [3:0] v, input logic rdy, input logic rst);
    req_valid = v;
    rsp_ready = rdy;
    reset     = rst;
    expReady  = '0;
    expHs     = 1'b0;
    expAny    = 1'b0;
    expG      = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!expAny && v[(mPtr + k) % NREQ]) begin
        expAny = 1'b1;
        expG   = (mPtr + k) % NREQ;
      end
    end
    if (expAny && !rst && (!mHold || rdy)) begin
      expHs          = 1'b1;
      expReady[expG] = 1'b1;
    end
    #1;
  endtask

  // Updates the scoreboard for the coming edge, then moves just past it.
  task automatic advance();
    if (reset) begin
      sb.delete();
      mHold = 1'b0;
      mPtr  = 0;
    end else begin
      if (mHold && rsp_ready && sb.size() > 0) begin
        eTmp  = sb.pop_front();
        mHold = 1'b0;
      end
      if (expHs) begin
        eTmp.id  = 2'(expG);
        eTmp.res = aluFn(opA[expG], opB[expG], opC[expG]);
        eTmp.flg = flagFn(opA[expG], opB[expG], opC[expG]);
        sb.push_back(eTmp);
        mHold = 1'b1;
        mPtr  = (expG + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(4'b1111, 1'b1, 1'b1);
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    advance();
    total++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== 39'd0) begin
      bad++;
      $display("[TB] FAIL reset_rsp: got valid=%b id=%0d result=%0h flags=%b expected all zero", rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
  endtask

  task automatic test_single();
    setOp(0, 32'd10, 32'd5, ALU_ADD);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL single_ready: got %b expected 0001", req_ready); end
    total++;
    if (alu_op1 !== 32'd10 || alu_op2 !== 32'd5 || alu_control !== ALU_ADD) begin
      bad++; $display("[TB] FAIL single_alu_in: got %0d/%0d/%b expected 10/5/0000", alu_op1, alu_op2, alu_control);
    end
    advance();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd15) begin
      bad++; $display("[TB] FAIL single_rsp: got v=%b id=%0d res=%0d expected v=1 id=0 res=15", rsp_valid, rsp_id, rsp_result);
    end
    total++;
    if (sb.size() != 1 || rsp_flags !== sb[0].flg) begin bad++; $display("[TB] FAIL single_flags: got %b", rsp_flags); end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    total++;
    if (alu_op1 !== 32'd0 || alu_op2 !== 32'd0 || alu_control !== 4'd0) begin
      bad++; $display("[TB] FAIL idle_alu_in: got %0h/%0h/%b expected 0/0/0", alu_op1, alu_op2, alu_control);
    end
    advance();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_drain: got rsp_valid=%b expected 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    applyStimulus(4'b0000, 1'b0, 1'b1);
    advance();
    setOp(0, 32'd15, 32'd3, ALU_ADD);
    setOp(1, 32'd15, 32'd3, ALU_SUB);
    setOp(2, 32'd15, 32'd3, ALU_OR);
    setOp(3, 32'd15, 32'd3, ALU_AND);
    for (int i = 0; i < NREQ; i++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      oh = 4'b0001 << i;
      total++;
      if (req_ready !== oh) begin bad++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, req_ready, oh); end
      advance();
      total++;
      if (rsp_valid !== 1'b1 || sb.size() != 1 || {rsp_id, rsp_result, rsp_flags} !== {sb[0].id, sb[0].res, sb[0].flg}) begin
        bad++; $display("[TB] FAIL rr_rsp%0d: got v=%b id=%0d res=%0d", i, rsp_valid, rsp_id, rsp_result);
      end
      if (i == 1) begin
        total++;
        if (rsp_result !== 32'd12) begin bad++; $display("[TB] FAIL rr_sub: got %0d expected 12", rsp_result); end
      end
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_backpressure();
    setOp(2, 32'd9, 32'd5, ALU_XOR);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    advance();
    total++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd12) begin bad++; $display("[TB] FAIL bp_first: got v=%b res=%0d expected 1/12", rsp_valid, rsp_result); end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0);
      total++;
      if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL bp_ready%0d: got %b expected 0000", i, req_ready); end
      advance();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'd12) begin
        bad++; $display("[TB] FAIL bp_hold%0d: got v=%b id=%0d res=%0d expected 1/2/12", i, rsp_valid, rsp_id, rsp_result);
      end
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    total++;
    if (req_ready !== 4'b1000) begin bad++; $display("[TB] FAIL bp_resume: got %b expected 1000", req_ready); end
    advance();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || sb.size() != 1 || rsp_result !== sb[0].res) begin
      bad++; $display("[TB] FAIL bp_next: got v=%b id=%0d res=%0d", rsp_valid, rsp_id, rsp_result);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_wrap();
    applyStimulus(4'b0100, 1'b1, 1'b0);
    advance();
    applyStimulus(4'b1001, 1'b1, 1'b0);
    total++;
    if (req_ready !== 4'b1000) begin bad++; $display("[TB] FAIL wrap_first: got %b expected 1000", req_ready); end
    advance();
    total++;
    if (rsp_id !== 2'd3) begin bad++; $display("[TB] FAIL wrap_id3: got %0d expected 3", rsp_id); end
    applyStimulus(4'b1001, 1'b1, 1'b0);
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL wrap_second: got %b expected 0001", req_ready); end
    advance();
    total++;
    if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL wrap_id0: got id=%0d v=%b expected 0/1", rsp_id, rsp_valid); end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_reset_in_resp();
    setOp(1, 32'd8, 32'd12, ALU_AND);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    advance();
    total++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd8) begin bad++; $display("[TB] FAIL rir_and: got v=%b res=%0d expected 1/8", rsp_valid, rsp_result); end
    applyStimulus(4'b1111, 1'b1, 1'b1);
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL rir_ready: got %b expected 0000", req_ready); end
    advance();
    total++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_id !== 2'd0) begin
      bad++; $display("[TB] FAIL rir_cleared: got v=%b res=%0d id=%0d expected 0/0/0", rsp_valid, rsp_result, rsp_id);
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL rir_ptr: got %b expected 0001", req_ready); end
    advance();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        setOp(i, $urandom_range(0, 255), $urandom_range(0, 255), 4'($urandom_range(0, 4)));
      end
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b0);
      total++;
      if (req_ready !== expReady) begin bad++; $display("[TB] FAIL rnd_ready%0d: got %b expected %b", c, req_ready, expReady); end
      if (expAny) begin
        total++;
        if (alu_op1 !== opA[expG] || alu_op2 !== opB[expG] || alu_control !== opC[expG]) begin
          bad++; $display("[TB] FAIL rnd_alu_in%0d: got %0h/%0h/%b for grant %0d", c, alu_op1, alu_op2, alu_control, expG);
        end
      end
      advance();
      total++;
      if (rsp_valid !== mHold) begin bad++; $display("[TB] FAIL rnd_valid%0d: got %b expected %b", c, rsp_valid, mHold); end
      if (mHold && sb.size() > 0) begin
        total++;
        if ({rsp_id, rsp_result, rsp_flags} !== {sb[0].id, sb[0].res, sb[0].flg}) begin
          bad++; $display("[TB] FAIL rnd_rsp%0d: got id=%0d res=%0h flg=%b expected id=%0d res=%0h flg=%b",
                          c, rsp_id, rsp_result, rsp_flags, sb[0].id, sb[0].res, sb[0].flg);
        end
      end
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    advance();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    applyStimulus(4'b0000, 1'b0, 1'b1);
    advance();
    total++;
    if (perf_ops !== 32'd0 || perf_stall !== 32'd0) begin bad++; $display("[TB] FAIL stats_reset: got %0d/%0d expected 0/0", perf_ops, perf_stall); end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0001, 1'b1, 1'b0);
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b0000, 1'b0, 1'b0);
      advance();
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    advance();
    total++;
    if (perf_ops !== 32'd5 || perf_stall !== 32'd2) begin bad++; $display("[TB] FAIL stats_count: got ops=%0d stall=%0d expected 5/2", perf_ops, perf_stall); end
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    mPtr      = 0;
    mHold     = 1'b0;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_op1   = '0;
    req_op2   = '0;
    req_ctrl  = '0;
    for (int i = 0; i < NREQ; i++) setOp(i, 32'd0, 32'd0, ALU_ADD);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_in_resp();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand/result width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, the number of requesters (2..8).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_op1  in  NREQ x WIDTH  first operand per requester
- req_op2  in  NREQ x WIDTH  second operand per requester
- req_ctrl  in  NREQ x 4  ALU control code per requester
- alu_op1  out  WIDTH  first operand to the shared ALU
- alu_op2  out  WIDTH  second operand to the shared ALU
- alu_control  out  4  control code to the shared ALU
- alu_result  in  WIDTH  combinational ALU result
- alu_flags  in  4  combinational ALU flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer accept
- rsp_id  out  clog2(NREQ)  index of the requester that issued the response
- rsp_result  out  WIDTH  registered ALU result
- rsp_flags  out  4  registered ALU flags

Function
REQ-004 The block SHALL share one combinational ALU among NREQ requesters using round-robin arbitration.
REQ-005 The FSM SHALL have two states: IDLE (no response held) and RESP (response held, rsp_valid=1).
REQ-006 Grant SHALL go to the first requester with valid asserted, searching from rr_ptr upward and wrapping from NREQ-1 to 0.
REQ-007 Issue SHALL be enabled when state==IDLE, or when state==RESP and rsp_ready==1.
REQ-008 req_ready[g] SHALL be 1 only for the granted index g, and only when issue is enabled; all other bits SHALL be 0.
REQ-009 alu_op1, alu_op2 and alu_control SHALL equal the granted requester's fields whenever any req_valid is 1; when none is valid they SHALL be 0.
REQ-010 On a handshake (req_valid[g] & req_ready[g]), the block SHALL register alu_result, alu_flags and g into rsp_result, rsp_flags and rsp_id, set the state to RESP, and set rr_ptr to (g+1) mod NREQ.
REQ-011 Latency SHALL be one cycle (response valid the cycle after acceptance); throughput SHALL be one operation per cycle while rsp_ready==1.
REQ-012 When state==RESP and rsp_ready==1 with no new handshake, the state SHALL return to IDLE and rsp_valid SHALL drop.
REQ-013 When state==RESP and rsp_ready==0, all rsp_* outputs SHALL hold stable and req_ready SHALL be all zero.
REQ-014 Simultaneous rsp_ready and a new handshake SHALL replace the response in the same edge, with no bubble.
REQ-015 rr_ptr SHALL change only on a handshake.

Reset
REQ-016 reset SHALL force the state to IDLE, rr_ptr to 0, and rsp_valid, rsp_id, rsp_result and rsp_flags to 0.
REQ-017 Reset SHALL dominate any concurrent handshake; an in-flight response SHALL be discarded.
REQ-018 req_ready SHALL be 0 in any cycle where reset==1.

Configuration
REQ-019 With ALU_ARB_STATS_EN defined, the block SHALL add outputs perf_ops (32 bits, counts handshakes) and perf_stall (32 bits, counts cycles with state==RESP and rsp_ready==0).
REQ-020 Both counters SHALL wrap at 2^32, clear on reset, and be read combinationally from their registers.
REQ-021 Without ALU_ARB_STATS_EN, the perf_* ports and counters SHALL be absent.

Structure
REQ-022 Package alu_arb_pkg SHALL hold the ALU control constants (ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100) and the FSM state enum.
REQ-023 Round-robin selection SHALL be a sub-module rr_arbiter with inputs (req, ptr) and outputs (gnt_onehot, gnt_idx, any), purely combinational.

Verification
REQ-024 Single request: req_valid=0001, op1=10, op2=5, ctrl=ADD, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=15.
REQ-025 All four valid for 4 cycles, rsp_ready=1 -> grant order 0,1,2,3, one rsp per cycle; SUB 15-3 on requester 1 -> rsp_result=12.
REQ-026 Backpressure: rsp_ready=0 for 3 cycles with the response holding XOR 9^5=12 -> rsp stable at 12, req_ready=0000; rsp_ready=1 -> next grant proceeds.
REQ-027 Wrap: rr_ptr=3, req_valid=1001 -> grant 3, then grant 0.
REQ-028 Reset asserted in RESP (response AND 8&12=8) -> next cycle rsp_valid=0, rsp_result=0, rr_ptr=0.
REQ-029 With ALU_ARB_STATS_EN: 5 handshakes and 2 stall cycles -> perf_ops=5, perf_stall=2.
